// File: rtl/givens_matrix_gen.sv
// Givens rotation matrix generator.
// Accepts a rotation command (c, s, i, j), builds the NxN rotation matrix
// either from identity or on top of the previously built matrix, then streams
// it out one row per beat.
// Optional feature macro: GIVENS_TRANSPOSE_EN adds cmd_transpose, which places
// the negated sine at M[j][i] instead of M[i][j] (builds G^T directly).
//
// Handshake rule for both the cmd and out channels: a transfer happens on a
// rising clock edge where valid && ready are both high; a source holding valid
// keeps its payload stable until that edge, and ready never depends on valid.
module givens_matrix_gen #(
    parameter int            N   = 4,
    parameter int            W   = 32,
    parameter logic [W-1:0]  ONE = 32'h3F800000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [W-1:0]           cmd_c,
    input  logic [W-1:0]           cmd_s,
    input  logic [$clog2(N)-1:0]   cmd_i,
    input  logic [$clog2(N)-1:0]   cmd_j,
    input  logic                   cmd_overlay,
`ifdef GIVENS_TRANSPOSE_EN
    input  logic                   cmd_transpose,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*W-1:0]         out_row,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last,
    output logic                   err,
    output logic [1:0]             dbg_state
);

    localparam int             IW       = $clog2(N);
    localparam logic [IW:0]    N_EXT    = (IW+1)'(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N-1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUILD  = 2'd1,
        STREAM = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [W-1:0]    c_q;
    logic [W-1:0]    s_q;
    logic [IW-1:0]   i_q;
    logic [IW-1:0]   j_q;
    logic            ov_q;
    logic [W-1:0]    mat   [N][N];
    logic [W-1:0]    mat_b [N][N];
    logic            cmd_legal;
    logic            cmd_fire;
    logic            neg_ij;
    logic [W-1:0]    s_neg;
    int              ii;
    int              jj;

`ifdef GIVENS_TRANSPOSE_EN
    logic            tr_q;
    // Transposed form moves the negated sine from M[i][j] to M[j][i].
    assign neg_ij = ~tr_q;
`else
    assign neg_ij = 1'b1;
`endif

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_legal = (cmd_i != cmd_j) && ({1'b0, cmd_i} < N_EXT) && ({1'b0, cmd_j} < N_EXT);
    // Negation is a pure sign-bit flip; no arithmetic is performed on elements.
    assign s_neg     = {~s_q[W-1], s_q[W-2:0]};
    assign ii        = int'(i_q);
    assign jj        = int'(j_q);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake/output decode.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        err       = 1'b0;
        out_row   = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nx = cmd_legal ? BUILD : ERR;
                end
            end
            BUILD: begin
                state_nx = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = (out_idx == LAST_IDX);
                for (int n = 0; n < N; n++) begin
                    out_row[n*W +: W] = mat[out_idx][n];
                end
                if (out_ready && (out_idx == LAST_IDX)) begin
                    state_nx = IDLE;
                end
            end
            ERR: begin
                err      = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Matrix image produced by the BUILD cycle: base (stored or identity) with the
    // four rotation entries overwritten.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                mat_b[r][k] = ov_q ? mat[r][k] : ((r == k) ? ONE : '0);
                if ((r == ii && k == ii) || (r == jj && k == jj)) begin
                    mat_b[r][k] = c_q;
                end else if (r == ii && k == jj) begin
                    mat_b[r][k] = neg_ij ? s_neg : s_q;
                end else if (r == jj && k == ii) begin
                    mat_b[r][k] = neg_ij ? s_q : s_neg;
                end
            end
        end
    end

    // Command capture, matrix storage and output row pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_q     <= '0;
            s_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ov_q    <= 1'b0;
`ifdef GIVENS_TRANSPOSE_EN
            tr_q    <= 1'b0;
`endif
            out_idx <= '0;
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    mat[r][k] <= (r == k) ? ONE : '0;
                end
            end
        end else begin
            if (cmd_fire) begin
                c_q  <= cmd_c;
                s_q  <= cmd_s;
                i_q  <= cmd_i;
                j_q  <= cmd_j;
                ov_q <= cmd_overlay;
`ifdef GIVENS_TRANSPOSE_EN
                tr_q <= cmd_transpose;
`endif
            end
            if (state == BUILD) begin
                for (int r = 0; r < N; r++) begin
                    for (int k = 0; k < N; k++) begin
                        mat[r][k] <= mat_b[r][k];
                    end
                end
            end
            if (state == STREAM && out_ready) begin
                out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_givens_matrix_gen.sv
// Bench for givens_matrix_gen: an N=4 instance for the main function and an
// N=6 instance for out-of-range index rejection.
module tb_givens_matrix_gen;

    localparam int W = 32;
    localparam logic [W-1:0] ONE = 32'h3F800000;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // ---------------- N=4 instance ----------------
    logic           cmd_valid, cmd_ready, cmd_overlay;
    logic [W-1:0]   cmd_c, cmd_s;
    logic [1:0]     cmd_i, cmd_j;
    logic           out_valid, out_ready, out_last, err;
    logic [127:0]   out_row;
    logic [1:0]     out_idx, dbg_state;

    givens_matrix_gen #(.N(4), .W(W), .ONE(ONE)) u4 (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_c(cmd_c), .cmd_s(cmd_s), .cmd_i(cmd_i), .cmd_j(cmd_j),
        .cmd_overlay(cmd_overlay),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_idx(out_idx), .out_last(out_last), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- N=6 instance ----------------
    logic           cmd_valid6, cmd_ready6, cmd_overlay6;
    logic [W-1:0]   cmd_c6, cmd_s6;
    logic [2:0]     cmd_i6, cmd_j6;
    logic           out_valid6, out_ready6, out_last6, err6;
    logic [191:0]   out_row6;
    logic [2:0]     out_idx6;
    logic [1:0]     dbg_state6;

    givens_matrix_gen #(.N(6), .W(W), .ONE(ONE)) u6 (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6),
        .cmd_c(cmd_c6), .cmd_s(cmd_s6), .cmd_i(cmd_i6), .cmd_j(cmd_j6),
        .cmd_overlay(cmd_overlay6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_row(out_row6),
        .out_idx(out_idx6), .out_last(out_last6), .err(err6), .dbg_state(dbg_state6)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q[$];
    logic [W-1:0] m [4][4];

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model of the stored N=4 matrix.
    task automatic model_reset();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                m[r][k] = (r == k) ? ONE : '0;
    endtask

    task automatic model_rot(input logic [W-1:0] c, input logic [W-1:0] s,
                             input int i, input int j, input logic ov);
        if (!ov) model_reset();
        m[i][i] = c;
        m[j][j] = c;
        m[j][i] = s;
        m[i][j] = {~s[W-1], s[W-2:0]};
    endtask

    task automatic push_model();
        for (int r = 0; r < 4; r++)
            exp_q.push_back({m[r][3], m[r][2], m[r][1], m[r][0]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic send4(input logic [W-1:0] c, input logic [W-1:0] s,
                         input logic [1:0] i, input logic [1:0] j, input logic ov);
        cmd_c = c; cmd_s = s; cmd_i = i; cmd_j = j; cmd_overlay = ov;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Collects 4 rows, comparing against exp_q; optional out_ready toggling.
    task automatic collect4(input bit toggle, output int wait_c);
        logic [127:0] held_row;
        logic [1:0]   held_idx;
        logic [127:0] exp_row;
        bit stalled = 0;
        int got = 0;
        int budget = 0;
        wait_c = 0;
        held_row = '0;
        held_idx = '0;
        while (got < 4 && budget < 40) begin
            out_ready = toggle ? ((budget % 2) == 0) : 1'b1;
            if (out_valid) begin
                if (stalled) begin
                    check("stall_row", out_row, held_row);
                    check("stall_idx", out_idx, held_idx);
                end
                check("cmd_ready_busy", cmd_ready, 1'b0);
                if (out_ready) begin
                    exp_row = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    check("row", out_row, exp_row);
                    check("idx", out_idx, got);
                    check("last", out_last, got == 3);
                    got++;
                    stalled = 0;
                end else begin
                    held_row = out_row;
                    held_idx = out_idx;
                    stalled  = 1;
                end
            end else if (got == 0) begin
                wait_c++;
            end
            tick();
            budget++;
        end
        check("stream_count", got, 4);
        out_ready = 1'b1;
    endtask

    // Full transaction on u4: command, BUILD check, stream, return-to-idle check.
    task automatic run4(input logic [W-1:0] c, input logic [W-1:0] s,
                        input logic [1:0] i, input logic [1:0] j, input logic ov,
                        input bit toggle, input bit use_model);
        int wait_c;
        model_rot(c, s, i, j, ov);
        if (use_model) push_model();
        send4(c, s, i, j, ov);
        check("build_state", dbg_state, 2'd1);
        check("build_novalid", out_valid, 1'b0);
        check("build_busy", cmd_ready, 1'b0);
        tick();
        collect4(toggle, wait_c);
        check("row0_latency", wait_c, 0);
        check("post_ready", cmd_ready, 1'b1);
        check("post_novalid", out_valid, 1'b0);
        check("post_idx", out_idx, 2'd0);
    endtask

    task automatic err6_cmd(input logic [2:0] i, input logic [2:0] j);
        cmd_c6 = 32'h3F000000; cmd_s6 = 32'h3F000000;
        cmd_i6 = i; cmd_j6 = j; cmd_overlay6 = 1'b1;
        cmd_valid6 = 1'b1;
        check("cmd_ready6_idle", cmd_ready6, 1'b1);
        tick();
        cmd_valid6 = 1'b0;
        check("err6_pulse", err6, 1'b1);
        check("err6_state", dbg_state6, 2'd3);
        check("err6_novalid", out_valid6, 1'b0);
        check("err6_busy", cmd_ready6, 1'b0);
        tick();
        check("err6_clear", err6, 1'b0);
        check("err6_idle", cmd_ready6, 1'b1);
        check("err6_novalid2", out_valid6, 1'b0);
    endtask

    function automatic logic [191:0] exp6_row(input int r);
        logic [191:0] v;
        v = '0;
        case (r)
            0:       v = {32'hBE400000, 128'h0, 32'h3F700000};
            5:       v = {32'h3F700000, 128'h0, 32'h3E400000};
            default: v[r*32 +: 32] = ONE;
        endcase
        return v;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int budget;
        int got6;
        reset = 1'b1;
        cmd_valid = 0; cmd_c = '0; cmd_s = '0; cmd_i = '0; cmd_j = '0; cmd_overlay = 0;
        out_ready = 1'b1;
        cmd_valid6 = 0; cmd_c6 = '0; cmd_s6 = '0; cmd_i6 = '0; cmd_j6 = '0; cmd_overlay6 = 0;
        out_ready6 = 1'b1;
        model_reset();

        #12;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_idx", out_idx, 2'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_out_row", out_row, 128'h0);
        check("rst_state", dbg_state, 2'd0);
        tick();
        reset = 1'b0;
        tick();

        // Rotation (0,2), c=s=0.7071 from identity.
        exp_q.push_back({32'h0, 32'hBF3504F3, 32'h0, 32'h3F3504F3});
        exp_q.push_back({32'h0, 32'h0, ONE, 32'h0});
        exp_q.push_back({32'h0, 32'h3F3504F3, 32'h0, 32'h3F3504F3});
        exp_q.push_back({ONE, 32'h0, 32'h0, 32'h0});
        run4(32'h3F3504F3, 32'h3F3504F3, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);

        // Rotation (1,3) with negative sine, stream under toggling backpressure.
        exp_q.push_back({32'h0, 32'h0, 32'h0, ONE});
        exp_q.push_back({32'h3F000000, 32'h0, 32'h3F5DB3D7, 32'h0});
        exp_q.push_back({32'h0, ONE, 32'h0, 32'h0});
        exp_q.push_back({32'h3F5DB3D7, 32'h0, 32'hBF000000, 32'h0});
        run4(32'h3F5DB3D7, 32'hBF000000, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0);

        // Overlay chain: (0,1) fresh, (2,3) overlaid, (2,3) fresh, (3,1) overlaid.
        run4(32'h3F400000, 32'h3E800000, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
        run4(32'h3F000000, 32'h3F600000, 2'd2, 2'd3, 1'b1, 1'b0, 1'b1);
        run4(32'h3F000000, 32'h3F600000, 2'd2, 2'd3, 1'b0, 1'b1, 1'b1);
        run4(32'h3F200000, 32'hBE000000, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1);

        // Illegal i==j on N=4: error pulse, matrix untouched for next overlay.
        send4(32'h12345678, 32'h9ABCDEF0, 2'd1, 2'd1, 1'b1);
        check("err4_pulse", err, 1'b1);
        check("err4_novalid", out_valid, 1'b0);
        tick();
        check("err4_clear", err, 1'b0);
        check("err4_idle", cmd_ready, 1'b1);
        run4(32'h3E000000, 32'h3F100000, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1);

        // Reset while row 2 is being presented.
        model_rot(32'h3F400000, 32'h3E800000, 0, 1, 1'b0);
        send4(32'h3F400000, 32'h3E800000, 2'd0, 2'd1, 1'b0);
        tick();
        tick();
        tick();
        check("pre_rst_idx", out_idx, 2'd2);
        check("pre_rst_valid", out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_ready", cmd_ready, 1'b1);
        check("midrst_idx", out_idx, 2'd0);
        check("midrst_row", out_row, 128'h0);
        check("midrst_last", out_last, 1'b0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        tick();
        run4(32'h3F000000, 32'h3F600000, 2'd2, 2'd3, 1'b1, 1'b0, 1'b1);

        // N=6: illegal i==j and out-of-range i, then legal overlay on identity.
        err6_cmd(3'd2, 3'd2);
        err6_cmd(3'd6, 3'd1);
        cmd_c6 = 32'h3F700000; cmd_s6 = 32'h3E400000;
        cmd_i6 = 3'd0; cmd_j6 = 3'd5; cmd_overlay6 = 1'b1;
        cmd_valid6 = 1'b1;
        tick();
        cmd_valid6 = 1'b0;
        check("n6_build_novalid", out_valid6, 1'b0);
        tick();
        got6 = 0;
        budget = 0;
        while (got6 < 6 && budget < 30) begin
            if (out_valid6) begin
                check("n6_row", out_row6, exp6_row(got6));
                check("n6_idx", out_idx6, got6);
                check("n6_last", out_last6, got6 == 5);
                got6++;
            end
            tick();
            budget++;
        end
        check("n6_count", got6, 6);
        check("n6_post_ready", cmd_ready6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
